// File: rtl/alu_control_mc.sv
// ALU control decode for a multi-cycle MIPS-style EX stage, plus the sequencer
// that issues mult/div, holds the front end while it runs and strobes HI/LO.
module alu_control_mc #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4,
  parameter int MD_LAT  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic               flush,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ALUCtrl,
  output logic               JumpReg,
  output logic               Shift,
  output logic               Jalr,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               hilo_we,
  output logic               hilo_sel,
  output logic               stall,
  output logic [1:0]         state_dbg
);

  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] OP_R   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] OP_BNE = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] OP_SLT = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] OP_XOR = ALUOP_W'(3'b111);

  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'h02);
  localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'(6'h03);
  localparam logic [FUNCT_W-1:0] F_JR    = FUNCT_W'(6'h08);
  localparam logic [FUNCT_W-1:0] F_JALR  = FUNCT_W'(6'h09);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'h10);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'h12);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'h19);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'h1A);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'h1B);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'h22);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'h26);
  localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'(6'h27);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'h2A);

  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_BNE = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_NOR = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] C_XOR = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] C_SRA = CTRL_W'(4'b1011);
  localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b1100);

  localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       muldiv;
  logic       mfhilo;
  logic       issue;
  logic       busy;

  always_comb begin
    ALUCtrl  = C_AND;
    JumpReg  = 1'b0;
    Shift    = 1'b0;
    Jalr     = 1'b0;
    muldiv   = 1'b0;
    mfhilo   = 1'b0;
    hilo_sel = 1'b0;
    case (ALUOp)
      OP_ADD: ALUCtrl = C_ADD;
      OP_SUB: ALUCtrl = C_SUB;
      OP_BNE: ALUCtrl = C_BNE;
      OP_SLT: ALUCtrl = C_SLT;
      OP_AND: ALUCtrl = C_AND;
      OP_OR:  ALUCtrl = C_OR;
      OP_XOR: ALUCtrl = C_XOR;
      OP_R: begin
        case (funct)
          F_SLL:  begin ALUCtrl = C_SLL; Shift = 1'b1; end
          F_SRL:  begin ALUCtrl = C_SRL; Shift = 1'b1; end
          F_SRA:  begin ALUCtrl = C_SRA; Shift = 1'b1; end
          F_JR:   JumpReg = 1'b1;
          F_JALR: begin JumpReg = 1'b1; Jalr = 1'b1; end
          F_ADD:  ALUCtrl = C_ADD;
          F_SUB:  ALUCtrl = C_SUB;
          F_AND:  ALUCtrl = C_AND;
          F_OR:   ALUCtrl = C_OR;
          F_XOR:  ALUCtrl = C_XOR;
          F_NOR:  ALUCtrl = C_NOR;
          F_SLT:  ALUCtrl = C_SLT;
          // mult/div keep ALUCtrl at its zero default; the ALU result is unused.
          F_MULT, F_MULTU, F_DIV, F_DIVU: muldiv = 1'b1;
          F_MFHI: begin mfhilo = 1'b1; hilo_sel = 1'b1; end
          F_MFLO: mfhilo = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Handshake: valid qualifies the EX-stage instruction; stall is the only
  // back-pressure (the EX stage may advance when stall=0), and flush kills
  // the instruction in the cycle it is seen, overriding valid.
  assign busy     = (state == S_BUSY);
  assign issue    = (state == S_IDLE) && valid && muldiv && !flush;
  assign md_start = rst_n && issue;
  assign stall    = rst_n && (issue || busy || (valid && mfhilo && (busy || issue)));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      md_op   <= 2'b00;
      hilo_we <= 1'b0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state <= S_BUSY;
            cnt   <= CNT_LOAD;
            md_op <= funct[1:0];
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end else if (cnt == 8'd0) begin
            state   <= S_DONE;
            hilo_we <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // The held muldiv is still valid here, so DONE must not re-issue.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: two instances (MD_LAT=4 and MD_LAT=2) share one
// set of inputs and are checked every cycle against a timeline model.
module tb_alu_control_mc;

  localparam int NDUT = 2;
  localparam int LAT0 = 4;
  localparam int LAT1 = 2;
  localparam logic [2:0] R = 3'b010;

  localparam int S_STALL = 0, S_START = 1, S_WE = 2, S_OP = 3, S_CTRL = 4;
  localparam int S_JR = 5, S_SH = 6, S_JALR = 7, S_SEL = 8;

  logic       clk, rst_n, valid, flush;
  logic [2:0] ALUOp;
  logic [5:0] funct;

  logic [3:0] ctrl_o  [NDUT];
  logic       jr_o    [NDUT];
  logic       sh_o    [NDUT];
  logic       jalr_o  [NDUT];
  logic       start_o [NDUT];
  logic       we_o    [NDUT];
  logic       sel_o   [NDUT];
  logic       stall_o [NDUT];
  logic [1:0] op_o    [NDUT];
  logic [1:0] st_o    [NDUT];

  alu_control_mc #(.MD_LAT(LAT0)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .ALUOp(ALUOp), .funct(funct),
    .ALUCtrl(ctrl_o[0]), .JumpReg(jr_o[0]), .Shift(sh_o[0]), .Jalr(jalr_o[0]),
    .md_start(start_o[0]), .md_op(op_o[0]), .hilo_we(we_o[0]), .hilo_sel(sel_o[0]),
    .stall(stall_o[0]), .state_dbg(st_o[0])
  );

  alu_control_mc #(.MD_LAT(LAT1)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .ALUOp(ALUOp), .funct(funct),
    .ALUCtrl(ctrl_o[1]), .JumpReg(jr_o[1]), .Shift(sh_o[1]), .Jalr(jalr_o[1]),
    .md_start(start_o[1]), .md_op(op_o[1]), .hilo_we(we_o[1]), .hilo_sel(sel_o[1]),
    .stall(stall_o[1]), .state_dbg(st_o[1])
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] ctrl;
    logic       jr, sh, jalr, md, mf, sel;
  } dec_t;

  function automatic dec_t ref_dec(input logic [2:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      3'b000: d.ctrl = 4'b0010;
      3'b001: d.ctrl = 4'b0110;
      3'b011: d.ctrl = 4'b0011;
      3'b100: d.ctrl = 4'b0111;
      3'b101: d.ctrl = 4'b0000;
      3'b110: d.ctrl = 4'b0001;
      3'b111: d.ctrl = 4'b1001;
      default: begin
        case (fn)
          6'h00: begin d.ctrl = 4'b1010; d.sh = 1'b1; end
          6'h02: begin d.ctrl = 4'b1100; d.sh = 1'b1; end
          6'h03: begin d.ctrl = 4'b1011; d.sh = 1'b1; end
          6'h08: d.jr = 1'b1;
          6'h09: begin d.jr = 1'b1; d.jalr = 1'b1; end
          6'h20: d.ctrl = 4'b0010;
          6'h22: d.ctrl = 4'b0110;
          6'h24: d.ctrl = 4'b0000;
          6'h25: d.ctrl = 4'b0001;
          6'h26: d.ctrl = 4'b1001;
          6'h27: d.ctrl = 4'b1000;
          6'h2A: d.ctrl = 4'b0111;
          6'h18, 6'h19, 6'h1A, 6'h1B: d.md = 1'b1;
          6'h10: begin d.mf = 1'b1; d.sel = 1'b1; end
          6'h12: d.mf = 1'b1;
          default: ;
        endcase
      end
    endcase
    return d;
  endfunction

  typedef struct {
    string      nm;
    int         k;
    int         sig;
    logic [7:0] val;
  } lit_t;

  lit_t       lit_q[$];
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         fin = 1'b0;
  bit         fin_done = 1'b0;

  bit         active [NDUT];
  int         iss_c  [NDUT];
  logic [1:0] op_m   [NDUT];
  int         lat    [NDUT];
  dec_t       d;
  logic       bz, dn, iss_e, st_e;
  logic [1:0] done_op;
  lit_t       le;

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    for (int k = 0; k < NDUT; k++) begin
      active[k] = 1'b0;
      iss_c[k]  = 0;
      op_m[k]   = 2'b00;
    end
  end

  function automatic logic [7:0] get_sig(input int k, input int sig);
    case (sig)
      S_STALL: return {7'd0, stall_o[k]};
      S_START: return {7'd0, start_o[k]};
      S_WE:    return {7'd0, we_o[k]};
      S_OP:    return {6'd0, op_o[k]};
      S_CTRL:  return {4'd0, ctrl_o[k]};
      S_JR:    return {7'd0, jr_o[k]};
      S_SH:    return {7'd0, sh_o[k]};
      S_JALR:  return {7'd0, jalr_o[k]};
      default: return {7'd0, sel_o[k]};
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (MD_LAT=%0d) cycle %0d: got %0h want %0h", nm, lat[k], cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    cyc++;
    d = ref_dec(ALUOp, funct);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        active[k] = 1'b0;
        op_m[k]   = 2'b00;
        bz = 1'b0; dn = 1'b0; iss_e = 1'b0;
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        bz    = active[k] && (cyc > iss_c[k]) && (cyc <= iss_c[k] + lat[k]);
        dn    = active[k] && (cyc == iss_c[k] + lat[k] + 1);
        iss_e = !bz && !dn && valid && d.md && !flush;
      end
      st_e = iss_e || bz || (valid && d.mf && (bz || iss_e));

      chk("ALUCtrl", k, {4'd0, ctrl_o[k]}, {4'd0, d.ctrl});
      chk("JumpReg", k, {7'd0, jr_o[k]}, {7'd0, d.jr});
      chk("Shift", k, {7'd0, sh_o[k]}, {7'd0, d.sh});
      chk("Jalr", k, {7'd0, jalr_o[k]}, {7'd0, d.jalr});
      chk("hilo_sel", k, {7'd0, sel_o[k]}, {7'd0, d.sel});
      chk("md_start", k, {7'd0, start_o[k]}, {7'd0, iss_e});
      chk("stall", k, {7'd0, stall_o[k]}, {7'd0, st_e});
      chk("hilo_we", k, {7'd0, we_o[k]}, {7'd0, dn});
      chk("md_op", k, {6'd0, op_o[k]}, {6'd0, op_m[k]});

      if (dn) begin
        if (k == 0) done_op = (exp_q0.size() > 0) ? exp_q0.pop_front() : 2'bxx;
        else        done_op = (exp_q1.size() > 0) ? exp_q1.pop_front() : 2'bxx;
        chk("done_md_op", k, {6'd0, op_o[k]}, {6'd0, done_op});
      end

      if (rst_n) begin
        if (iss_e) begin
          active[k] = 1'b1;
          iss_c[k]  = cyc;
          op_m[k]   = funct[1:0];
          if (k == 0) exp_q0.push_back(funct[1:0]); else exp_q1.push_back(funct[1:0]);
        end else if (bz && flush) begin
          active[k] = 1'b0;
          if (k == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (dn) begin
          active[k] = 1'b0;
        end
      end
    end

    while (lit_q.size() > 0) begin
      le = lit_q.pop_front();
      chk(le.nm, le.k, get_sig(le.k, le.sig), le.val);
    end

    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk("pending_ops", 0, 8'(exp_q0.size()), 8'd0);
      chk("pending_ops", 1, 8'(exp_q1.size()), 8'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic fl, input logic [2:0] op, input logic [5:0] fn);
    valid = v;
    flush = fl;
    ALUOp = op;
    funct = fn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int k, input int sig, input logic [7:0] v);
    lit_t e;
    e.nm  = nm;
    e.k   = k;
    e.sig = sig;
    e.val = v;
    lit_q.push_back(e);
  endtask

  task automatic settle();
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    repeat (8) tick();
  endtask

  // {ALUOp, funct, ALUCtrl, JumpReg, Shift, Jalr, hilo_sel}
  localparam int NV = 23;
  logic [16:0] dv [NV] = '{
    {3'b000, 6'h15, 4'b0010, 4'b0000},
    {3'b001, 6'h00, 4'b0110, 4'b0000},
    {3'b011, 6'h2A, 4'b0011, 4'b0000},
    {3'b100, 6'h3F, 4'b0111, 4'b0000},
    {3'b101, 6'h20, 4'b0000, 4'b0000},
    {3'b110, 6'h07, 4'b0001, 4'b0000},
    {3'b111, 6'h11, 4'b1001, 4'b0000},
    {3'b010, 6'h00, 4'b1010, 4'b0100},
    {3'b010, 6'h02, 4'b1100, 4'b0100},
    {3'b010, 6'h03, 4'b1011, 4'b0100},
    {3'b010, 6'h08, 4'b0000, 4'b1000},
    {3'b010, 6'h09, 4'b0000, 4'b1010},
    {3'b010, 6'h20, 4'b0010, 4'b0000},
    {3'b010, 6'h22, 4'b0110, 4'b0000},
    {3'b010, 6'h24, 4'b0000, 4'b0000},
    {3'b010, 6'h25, 4'b0001, 4'b0000},
    {3'b010, 6'h26, 4'b1001, 4'b0000},
    {3'b010, 6'h27, 4'b1000, 4'b0000},
    {3'b010, 6'h2A, 4'b0111, 4'b0000},
    {3'b010, 6'h10, 4'b0000, 4'b0001},
    {3'b010, 6'h12, 4'b0000, 4'b0000},
    {3'b010, 6'h21, 4'b0000, 4'b0000},
    {3'b010, 6'h3F, 4'b0000, 4'b0000}
  };

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] v;
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, R, 6'h1A);
    repeat (2) tick();
    lit("rst_stall", 0, S_STALL, 8'd0);
    lit("rst_stall", 1, S_STALL, 8'd0);
    lit("rst_start", 0, S_START, 8'd0);
    lit("rst_we", 0, S_WE, 8'd0);
    lit("rst_md_op", 0, S_OP, 8'd0);
    tick();
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // Decode sweep; every third vector has valid=0 to show decode stays live.
    for (int i = 0; i < NV; i++) begin
      v = dv[i];
      set_in((i % 3) != 0, 1'b0, v[16:14], v[13:8]);
      lit("dec_ctrl", 0, S_CTRL, {4'd0, v[7:4]});
      lit("dec_jr", 0, S_JR, {7'd0, v[3]});
      lit("dec_shift", 0, S_SH, {7'd0, v[2]});
      lit("dec_jalr", 0, S_JALR, {7'd0, v[1]});
      lit("dec_sel", 0, S_SEL, {7'd0, v[0]});
      lit("dec_stall", 0, S_STALL, 8'd0);
      tick();
    end
    settle();

    // div issue at cycle 0, held through DONE.
    set_in(1'b1, 1'b0, R, 6'h1A);
    lit("div_start", 0, S_START, 8'd1);
    lit("div_ctrl", 0, S_CTRL, 8'd0);
    lit("div_stall_c0", 0, S_STALL, 8'd1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      lit("div_stall_busy", 0, S_STALL, 8'd1);
      lit("div_md_op", 0, S_OP, 8'd2);
      lit("div_no_we", 0, S_WE, 8'd0);
      tick();
    end
    lit("div_done_we", 0, S_WE, 8'd1);
    lit("div_done_stall", 0, S_STALL, 8'd0);
    lit("div_done_noissue", 0, S_START, 8'd0);
    tick();
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    lit("div_idle_we", 0, S_WE, 8'd0);
    lit("div_idle_stall", 0, S_STALL, 8'd0);
    tick();
    settle();

    // mult, then mfhi after DONE: no stall.
    set_in(1'b1, 1'b0, R, 6'h18);
    repeat (5) tick();
    lit("mult_done_we", 0, S_WE, 8'd1);
    tick();
    set_in(1'b1, 1'b0, R, 6'h10);
    lit("mfhi_late_stall", 0, S_STALL, 8'd0);
    lit("mfhi_late_sel", 0, S_SEL, 8'd1);
    tick();
    settle();

    // mult, then mfhi during BUSY at cycle 3: stall held until DONE.
    set_in(1'b1, 1'b0, R, 6'h18);
    repeat (3) tick();
    set_in(1'b1, 1'b0, R, 6'h10);
    lit("mfhi_busy_stall", 0, S_STALL, 8'd1);
    lit("mfhi_busy_sel", 0, S_SEL, 8'd1);
    tick();
    lit("mfhi_busy_stall4", 0, S_STALL, 8'd1);
    tick();
    lit("mfhi_done_stall", 0, S_STALL, 8'd0);
    lit("mfhi_done_we", 0, S_WE, 8'd1);
    tick();
    settle();

    // flush at cycle 2 of BUSY.
    set_in(1'b1, 1'b0, R, 6'h1A);
    repeat (2) tick();
    set_in(1'b1, 1'b1, R, 6'h1A);
    lit("flush_busy_stall", 0, S_STALL, 8'd1);
    tick();
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    for (int c = 3; c <= 8; c++) begin
      lit("flush_no_we", 0, S_WE, 8'd0);
      lit("flush_stall", 0, S_STALL, 8'd0);
      tick();
    end

    // flush in IDLE blocks issue; flush in DONE keeps hilo_we.
    set_in(1'b1, 1'b1, R, 6'h1B);
    lit("flush_idle_start", 0, S_START, 8'd0);
    lit("flush_idle_stall", 0, S_STALL, 8'd0);
    tick();
    set_in(1'b1, 1'b0, R, 6'h1B);
    lit("divu_start", 0, S_START, 8'd1);
    tick();
    lit("divu_md_op", 0, S_OP, 8'd3);
    repeat (4) tick();
    set_in(1'b1, 1'b1, R, 6'h1B);
    lit("flush_done_we", 0, S_WE, 8'd1);
    lit("flush_done_stall", 0, S_STALL, 8'd0);
    tick();
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    lit("after_done_we", 0, S_WE, 8'd0);
    tick();
    settle();

    // Reset at cycle 2 of BUSY, then a fresh full-length operation.
    set_in(1'b1, 1'b0, R, 6'h19);
    lit("multu_start", 0, S_START, 8'd1);
    repeat (2) tick();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 3'b000, 6'h00);
    lit("rst_busy_stall", 0, S_STALL, 8'd0);
    lit("rst_busy_stall", 1, S_STALL, 8'd0);
    lit("rst_busy_start", 0, S_START, 8'd0);
    lit("rst_busy_we", 0, S_WE, 8'd0);
    lit("rst_busy_md_op", 0, S_OP, 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      lit("rst_after_we", 0, S_WE, 8'd0);
      tick();
    end
    set_in(1'b1, 1'b0, R, 6'h18);
    for (int c = 0; c <= 4; c++) begin
      lit("reissue_stall", 0, S_STALL, 8'd1);
      tick();
    end
    lit("reissue_we", 0, S_WE, 8'd1);
    lit("reissue_stall_done", 0, S_STALL, 8'd0);
    tick();
    settle();

    // Back-to-back muldiv held valid: MD_LAT=2 re-issues every 4 cycles.
    set_in(1'b1, 1'b0, R, 6'h18);
    for (int c = 0; c <= 8; c++) begin
      lit("b2b_start", 1, S_START, {7'd0, (c % 4) == 0});
      lit("b2b_we", 1, S_WE, {7'd0, (c % 4) == 3});
      lit("b2b_start", 0, S_START, {7'd0, (c == 0) || (c == 6)});
      tick();
    end
    settle();

    fin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
